// File: rtl/arb_pkg.sv
// Shared types and sizes for the four-requester round-robin arbiter.
package arb_pkg;
    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;
endpackage

// File: rtl/rr_pick_4.sv
// Combinational round-robin pick: first set bit of req scanning from start upward, modulo 4.
module rr_pick_4
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] idx,
    output logic [N_REQ-1:0] onehot
);
    logic [2*N_REQ-1:0] w_dbl;
    logic [N_REQ-1:0]   w_rot;
    logic [IDX_W-1:0]   w_off;
    logic               w_any;

    // Rotate so bit 0 of w_rot corresponds to requester 'start'.
    assign w_dbl = {req, req} >> start;
    assign w_rot = w_dbl[N_REQ-1:0];

    always_comb begin
        w_off = '0;
        w_any = 1'b0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_off = IDX_W'(j);
                w_any = 1'b1;
            end
        end
    end

    assign found  = w_any;
    assign idx    = w_off + start;
    assign onehot = w_any ? (N_REQ'(1) << idx) : '0;
endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with bounded hold time under contention.
module rr_arbiter_4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);
    localparam int                HOLD_W   = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    state_t            r_state, w_state_nxt;
    logic [N_REQ-1:0]  r_gnt, w_gnt_nxt;
    logic [IDX_W-1:0]  r_idx, w_idx_nxt;
    logic              r_valid, w_valid_nxt;
    logic [IDX_W-1:0]  r_ptr, w_ptr_nxt;
    logic [HOLD_W-1:0] r_hold, w_hold_nxt;

    logic [N_REQ-1:0]  w_pick_req;
    logic              w_found;
    logic [IDX_W-1:0]  w_pick_idx;
    logic [N_REQ-1:0]  w_pick_onehot;
    logic              w_own_req;
    logic              w_take;

    // While granted, ptr already equals owner+1, so it serves as the search start in both states.
    assign w_pick_req = (r_state == GRANT) ? (req & ~r_gnt) : req;
    assign w_own_req  = req[r_idx];

    rr_pick_4 u_pick (
        .req    (w_pick_req),
        .start  (r_ptr),
        .found  (w_found),
        .idx    (w_pick_idx),
        .onehot (w_pick_onehot)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_idx_nxt   = r_idx;
        w_valid_nxt = r_valid;
        w_ptr_nxt   = r_ptr;
        w_hold_nxt  = r_hold;
        w_take      = 1'b0;

        case (r_state)
            IDLE: begin
                w_take = w_found;
            end
            GRANT: begin
                if (!w_own_req || (r_hold == HOLD_MAX)) begin
                    w_take = w_found;
                end
                if (!w_own_req && !w_found) begin
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_valid_nxt = 1'b0;
                    w_hold_nxt  = '0;
                end else if (w_own_req && !w_take && (r_hold != HOLD_MAX)) begin
                    w_hold_nxt = r_hold + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // New owner: a fresh grant, a back-to-back handoff on release, or a preemption.
        if (w_take) begin
            w_state_nxt = GRANT;
            w_gnt_nxt   = w_pick_onehot;
            w_idx_nxt   = w_pick_idx;
            w_valid_nxt = 1'b1;
            w_ptr_nxt   = w_pick_idx + 1'b1;
            w_hold_nxt  = HOLD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_ptr   <= '0;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_idx   <= w_idx_nxt;
            r_valid <= w_valid_nxt;
            r_ptr   <= w_ptr_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_idx;
    assign gnt_valid = r_valid;
endmodule

// File: doc/rr_arbiter_4.md
# rr_arbiter_4

Four-requester round-robin arbiter that shares one downstream resource, such as an encoder or datapath port, between four clients. It registers a one-hot grant plus its 2-bit encoded index. Requester i owns the resource while `req[i]` stays high, with a bounded hold time. It sits between the four request sources and the shared resource's select/enable inputs.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive grant cycles while other requesters wait. Legal range is ≥ 1.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `req`  in  4  request vector; bit i = requester i
- `gnt`  out  4  one-hot grant, registered; all-zero when idle
- `gnt_idx`  out  2  binary index of the set `gnt` bit; 0 when idle
- `gnt_valid`  out  1  high iff `gnt` is non-zero

## Operation
- States:
  - IDLE: no owner.
  - GRANT: one owner.
- Internal registers:
  - `ptr[1:0]`: search start.
  - `hold_cnt`: width clog2(MAX_HOLD+1).
- Pick function: first i with `req[i]`=1, scanning `ptr`, `ptr`+1, ... modulo 4.
  - `others` = `req` with the owner bit masked.
- IDLE:
  - If `req` = 0, stay IDLE.
  - Otherwise go to GRANT with winner w = pick(`req`, `ptr`).
  - Set `gnt` = 1<<w, `ptr` = w+1 mod 4, `hold_cnt` = 1.
- GRANT, owner o, evaluated every cycle:
  - Release (`req[o]`=0) with `others` ≠ 0: grant w = pick(`others`, o+1) back-to-back with no idle cycle. Set `ptr` = w+1, `hold_cnt` = 1.
  - Release with `others` = 0: go to IDLE, `gnt` = 0, `hold_cnt` = 0. `ptr` is unchanged (already o+1).
  - `req[o]`=1, `hold_cnt` = MAX_HOLD, `others` ≠ 0: preempt. Grant pick(`others`, o+1). Set `ptr` and `hold_cnt` as on release.
  - `req[o]`=1, `others` = 0: keep the grant. `hold_cnt` saturates at MAX_HOLD and does not wrap.
  - Otherwise: keep the grant, `hold_cnt` +1.
- Outputs:
  - `gnt` is always zero or one-hot, never multi-hot.
  - `gnt_idx` and `gnt_valid` are registered together with `gnt` and are always mutually consistent.
- Requests are level-based. A requester dropping `req` while not granted is simply skipped. No request is latched.

## Timing
- Reset (synchronous, sampled at a `clk` edge with `rst`=1) sets:
  - `gnt` = 0000, `gnt_idx` = 00, `gnt_valid` = 0
  - `ptr` = 0, `hold_cnt` = 0, state IDLE
- `rst` wins over every other event. A reset while granted drops the grant at that edge.
- Request-to-grant latency is 1 cycle: `req` sampled at edge k gives `gnt` valid after edge k.
- Release latency is 1 cycle: `req[o]` low at edge k means `gnt[o]` is low after edge k. The next owner, if any, is granted at that same edge.
- Maximum continuous hold under contention is MAX_HOLD cycles. With MAX_HOLD=1, a contended grant lasts exactly 1 cycle.
- Worst-case wait for a requester holding `req` high is 3×MAX_HOLD cycles plus 1 cycle latency.
- Simultaneous release and preemption condition: treat as release; the result is identical.
- Wrap-around: `ptr` = 3+1 wraps to 0.

## Structure
- Shared package `arb_pkg`:
  - `N_REQ` = 4
  - state enum {IDLE, GRANT}
  - `IDX_W` = 2
- Sub-module `rr_pick_4` (combinational):
  - Inputs: `req[3:0]`, `start[1:0]`.
  - Outputs: `found`, `idx[1:0]`, `onehot[3:0]`.
  - It rotates `req` by `start`, applies a fixed priority, then encodes and un-rotates.
  - The top level instantiates it once. The pick input is the masked `others` in GRANT and the full `req` in IDLE.
- Top level holds only the FSM, `ptr`, `hold_cnt` and the output registers.

## Test plan
- Reset, then `req`=0000 for 3 cycles: `gnt`=0000, `gnt_idx`=0, `gnt_valid`=0 throughout.
- After reset, `req`=0110 held: `gnt`=0010 one cycle later. With MAX_HOLD=8, after 8 cycles `gnt`=0100 for 8 cycles, then back to 0010.
- `req`=1111 held, MAX_HOLD=1: `gnt` sequence 0001, 0010, 0100, 1000, 0001 with `gnt_idx` 0,1,2,3,0. This checks wrap-around.
- `req`=0001 alone for 20 cycles: `gnt`=0001 the whole time, no preemption, `hold_cnt` saturated. Then `req`=0000: `gnt`=0000 one cycle later.
- Owner 2 granted with `req`=0101. Drop bit 2 (`req`=0001): next cycle `gnt`=0001 with no idle cycle between grants.
- Owner 3 granted. Assert `rst` for one cycle: `gnt`=0000 after that edge. With `req`=1001 held, the first post-reset grant is 0001 (`ptr` reset to 0).
